fetch_sequencer: RTL and testbench

Control block for the instruction-fetch stage. It owns the 8-bit program counter and drives the instruction block RAM, whose read data is registered: the address issued in cycle n returns data in cycle n+1. It delivers fetched words and their NPC to the IF/ID boundary, and handles three things:
- decode-stage stall backpressure, using a one-entry skid buffer;
- branch/jump redirects;
- halt/resume.

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch control: PC, registered-read BRAM issue,
//               one-entry skid buffer, redirect squash and halt/resume.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
    parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              resume,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_npc,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ADDR_W-1:0]   fetch_pc;
    logic                ifl;
    logic [ADDR_W-1:0]   ifl_addr;
    logic                skid_valid;
    logic [DATA_W-1:0]   skid_data;
    logic [ADDR_W-1:0]   skid_npc;

    logic                active;
    logic                halt_cap;

    assign active   = (state != ST_HALT);
    assign mem_addr = redirect ? redirect_pc : fetch_pc;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= ST_PRIME;
        end else begin
            state <= state_next;
        end
    end

    // The word reaching instr this cycle comes from the skid first, else from
    // the RAM; a halt word there blocks the next issue.
    always_comb begin
        state_next = state;
        halt_cap   = 1'b0;
        mem_en     = 1'b0;

        if (active && !redirect && !stall) begin
            if (skid_valid) begin
                halt_cap = (skid_data == HALT_WORD);
            end else if (ifl) begin
                halt_cap = (mem_rdata == HALT_WORD);
            end
        end

        mem_en = redirect | (active & ~stall & ~halt_cap);

        case (state)
            ST_PRIME: state_next = halt_cap ? ST_HALT : ST_RUN;
            ST_RUN:   state_next = halt_cap ? ST_HALT : ST_RUN;
            ST_HALT: begin
                if (redirect) begin
                    state_next = ST_RUN;
                end else if (resume) begin
                    state_next = ST_PRIME;
                end
            end
            default:  state_next = ST_PRIME;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            ifl         <= 1'b0;
            ifl_addr    <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_npc    <= '0;
            instr       <= '0;
            instr_npc   <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            ifl    <= mem_en;
            halted <= (state_next == ST_HALT);
            if (mem_en) begin
                ifl_addr <= mem_addr;
                fetch_pc <= mem_addr + ADDR_W'(1);
            end

            if (redirect) begin
                skid_valid  <= 1'b0;
                instr_valid <= 1'b0;
            end else if (stall) begin
                if (ifl && active) begin
                    skid_valid <= 1'b1;
                    skid_data  <= mem_rdata;
                    skid_npc   <= ifl_addr + ADDR_W'(1);
                end
            end else if (skid_valid) begin
                instr       <= skid_data;
                instr_npc   <= skid_npc;
                instr_valid <= 1'b1;
                skid_valid  <= 1'b0;
            end else if (ifl && active) begin
                instr       <= mem_rdata;
                instr_npc   <= ifl_addr + ADDR_W'(1);
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed scenarios plus random traffic for fetch_sequencer,
//               checked every cycle against a queue-based fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        resume;
    logic [31:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_en;
    logic [31:0] instr;
    logic [7:0]  instr_npc;
    logic        instr_valid;
    logic        halted;

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock       (clock),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .resume      (resume),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_en      (mem_en),
        .instr       (instr),
        .instr_npc   (instr_npc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    logic [31:0] ram [256];
    always @(posedge clock) if (mem_en) mem_rdata <= ram[mem_addr];

    // Model: words in flight, then words returned but not yet delivered.
    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  npc;
    } word_t;

    word_t       pend[$];
    logic [7:0]  infl[$];
    int          mode;          // 0 prime, 1 run, 2 halt
    logic [7:0]  m_pc;
    logic [31:0] e_instr;
    logic [7:0]  e_npc;
    logic        e_valid;
    logic        e_halted;
    logic        e_en;
    logic [7:0]  e_addr;
    logic        last_en;
    logic [7:0]  last_issue;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        infl.delete();
        mode     = 0;
        m_pc     = 8'h00;
        e_instr  = '0;
        e_npc    = '0;
        e_valid  = 1'b0;
        e_halted = 1'b0;
        last_en  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [7:0] rp, input logic rs);
        word_t      ret;
        word_t      w;
        logic       has_ret;
        logic       halt_now;
        logic [7:0] a;
        has_ret  = 1'b0;
        halt_now = 1'b0;
        ret      = '0;
        if (infl.size() > 0) begin
            a       = infl.pop_front();
            ret.d   = ram[a];
            ret.npc = a + 8'd1;
            has_ret = 1'b1;
        end
        if (r) begin
            pend.delete();
            e_valid = 1'b0;
        end else if (mode == 2) begin
            if (!s) e_valid = 1'b0;
        end else if (s) begin
            if (has_ret) pend.push_back(ret);
        end else begin
            if (has_ret) pend.push_back(ret);
            if (pend.size() > 0) begin
                w        = pend.pop_front();
                e_instr  = w.d;
                e_npc    = w.npc;
                e_valid  = 1'b1;
                halt_now = (w.d == HALT);
            end else begin
                e_valid = 1'b0;
            end
        end
        e_en   = r || (mode != 2 && !s && !halt_now);
        e_addr = r ? rp : m_pc;
        last_en = e_en;
        if (e_en) begin
            infl.push_back(e_addr);
            last_issue = e_addr;
            m_pc       = e_addr + 8'd1;
        end
        if (r)              mode = 1;
        else if (mode == 2) mode = rs ? 0 : 2;
        else if (halt_now)  mode = 2;
        else                mode = 1;
        e_halted = (mode == 2);
    endtask

    task automatic cycle(input logic s, input logic r, input logic [7:0] rp, input logic rs);
        stall = s; redirect = r; redirect_pc = rp; resume = rs;
        #1;
        model_step(s, r, rp, rs);
        chk("mem_en",   {31'd0, mem_en}, {31'd0, e_en});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, e_addr});
        @(posedge clock);
        #1;
        stall = 1'b0; redirect = 1'b0; resume = 1'b0;
        chk("instr",       instr, e_instr);
        chk("instr_npc",   {24'd0, instr_npc}, {24'd0, e_npc});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
        chk("halted",      {31'd0, halted}, {31'd0, e_halted});
    endtask

    initial begin
        int n;
        for (int k = 0; k < 256; k++) ram[k] = 32'h1000_0000 + k;
        ram[7] = HALT;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; resume = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_npc",   {24'd0, instr_npc}, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'h0);
        rst = 1'b0;

        // Sequential fetch: first word valid two cycles after its issue
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("t1_instr", instr, 32'h1000_0000);
        chk("t1_npc",   {24'd0, instr_npc}, 32'h1);
        chk("t1_valid", {31'd0, instr_valid}, 32'h1);

        // Stall with RAM[4] presented, skid holds RAM[5]
        n = 0;
        while (!(e_valid && e_instr == ram[4]) && n < 20) begin cycle(0, 0, 0, 0); n++; end
        chk("t2_reach", {31'd0, n < 20}, 32'h1);
        repeat (3) cycle(1, 0, 0, 0);
        chk("t2_hold", instr, 32'h1000_0004);
        cycle(0, 0, 0, 0);
        chk("t2_skid", instr, 32'h1000_0005);
        cycle(0, 0, 0, 0);
        chk("t2_next", instr, 32'h1000_0006);

        // Halt word at address 7
        n = 0;
        while (!e_halted && n < 20) begin cycle(0, 0, 0, 0); n++; end
        chk("t5_reach", {31'd0, n < 20}, 32'h1);
        chk("t5_instr", instr, HALT);
        chk("t5_npc",   {24'd0, instr_npc}, 32'h8);
        repeat (3) cycle(0, 0, 0, 0);
        chk("t5_valid", {31'd0, instr_valid}, 32'h0);
        cycle(0, 0, 0, 1);
        chk("t5_pc", {24'd0, mem_addr}, 32'h8);

        // Redirect while 0x09 is in flight
        n = 0;
        while (!(last_en && last_issue == 8'h09) && n < 20) begin cycle(0, 0, 0, 0); n++; end
        chk("t3_reach", {31'd0, n < 20}, 32'h1);
        cycle(0, 1, 8'h40, 0);
        chk("t3_bubble", {31'd0, instr_valid}, 32'h0);
        cycle(0, 0, 0, 0);
        chk("t3_instr", instr, 32'h1000_0040);
        chk("t3_npc",   {24'd0, instr_npc}, 32'h41);

        // Redirect while stalled with the skid full
        repeat (2) cycle(1, 0, 0, 0);
        cycle(1, 1, 8'h20, 0);
        chk("t4_bubble", {31'd0, instr_valid}, 32'h0);
        repeat (2) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("t4_instr", instr, 32'h1000_0020);
        cycle(0, 0, 0, 0);

        // Address wrap
        cycle(0, 1, 8'hFE, 0);
        cycle(0, 0, 0, 0);
        chk("t6_npc_ff", {24'd0, instr_npc}, 32'hFF);
        cycle(0, 0, 0, 0);
        chk("t6_npc_00", {24'd0, instr_npc}, 32'h00);
        cycle(0, 0, 0, 0);
        chk("t6_npc_01", {24'd0, instr_npc}, 32'h01);

        // Asynchronous reset mid-stream, without a clock edge
        rst = 1'b1;
        #1;
        chk("arst_instr",  instr, 32'h0);
        chk("arst_npc",    {24'd0, instr_npc}, 32'h0);
        chk("arst_valid",  {31'd0, instr_valid}, 32'h0);
        chk("arst_halted", {31'd0, halted}, 32'h0);
        model_reset();
        for (int k = 0; k < 256; k++) ram[k] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
        @(posedge clock);
        #1;
        rst = 1'b0;
        chk("arst_pc", {24'd0, mem_addr}, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0,
                  8'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
